// File: rtl/alu_exec_unit.sv
// Execute stage of the MIPS datapath: ALU control decode, WIDTH-bit ALU and the branch AND gate.
// One register stage: inputs sampled at a posedge show up on every output right after that edge.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             branch,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             pc_src
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_INV = 4'b1111;

  logic [3:0]       ctrl_next;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] result_next;
  logic             overflow_next;
  logic             zero_next;

  always_comb begin
    ctrl_next = OP_INV;
    case (alu_op)
      2'b00: ctrl_next = OP_ADD;
      2'b01: ctrl_next = OP_SUB;
      2'b11: ctrl_next = OP_OR;
      default: begin
        case (funct)
          6'b100000: ctrl_next = OP_ADD;
          6'b100010: ctrl_next = OP_SUB;
          6'b100100: ctrl_next = OP_AND;
          6'b100101: ctrl_next = OP_OR;
          6'b101010: ctrl_next = OP_SLT;
          6'b100111: ctrl_next = OP_NOR;
          default:   ctrl_next = OP_INV;
        endcase
      end
    endcase
  end

  assign sum  = a + b;
  assign diff = a - b;

  // Overflow only when the operands (b inverted for sub) agree in sign and the result does not.
  always_comb begin
    result_next   = '0;
    overflow_next = 1'b0;
    case (ctrl_next)
      OP_AND: result_next = a & b;
      OP_OR:  result_next = a | b;
      OP_ADD: begin
        result_next   = sum;
        overflow_next = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result_next   = diff;
        overflow_next = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: result_next[0] = $signed(a) < $signed(b);
      OP_NOR: result_next = ~(a | b);
      default: result_next = '0;
    endcase
  end

  assign zero_next = ~|result_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_ctrl <= 4'b0000;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      pc_src   <= 1'b0;
    end else begin
      alu_ctrl <= ctrl_next;
      result   <= result_next;
      zero     <= zero_next;
      overflow <= overflow_next;
      pc_src   <= branch & zero_next;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed MIPS cases plus random traffic, scored against an arithmetic model.
module tb_alu_exec_unit;
  localparam int W     = 32;
  localparam int EXP_W = 4 + W + 3;

  logic         clk;
  logic         rst;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         branch;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         pc_src;

  logic [EXP_W-1:0] exp_q[$];
  int checks;
  int errors;
  bit done;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .branch(branch), .alu_ctrl(alu_ctrl), .result(result), .zero(zero),
    .overflow(overflow), .pc_src(pc_src)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: pick the operation by name, then do the arithmetic in 64-bit signed space.
  function automatic logic [EXP_W-1:0] model(input logic rst_v, input logic [1:0] op,
                                             input logic [5:0] fn, input logic [W-1:0] av,
                                             input logic [W-1:0] bv, input logic br);
    logic [3:0]   code;
    logic [W-1:0] r;
    logic         ov;
    logic         z;
    longint       sa;
    longint       sb;
    longint       s;
    if (!rst_v) return '0;
    if (op == 2'd0)      code = 4'h2;
    else if (op == 2'd1) code = 4'h6;
    else if (op == 2'd3) code = 4'h1;
    else if (fn == 6'h20) code = 4'h2;
    else if (fn == 6'h22) code = 4'h6;
    else if (fn == 6'h24) code = 4'h0;
    else if (fn == 6'h25) code = 4'h1;
    else if (fn == 6'h2A) code = 4'h7;
    else if (fn == 6'h27) code = 4'hC;
    else                  code = 4'hF;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    r  = '0;
    ov = 1'b0;
    if (code == 4'h0) r = av & bv;
    else if (code == 4'h1) r = av | bv;
    else if (code == 4'h2 || code == 4'h6) begin
      s  = (code == 4'h2) ? sa + sb : sa - sb;
      r  = s[W-1:0];
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    else if (code == 4'h7) r = (sa < sb) ? 1 : 0;
    else if (code == 4'hC) r = ~(av | bv);
    z = (r == 0);
    return {code, r, z, ov, br & z};
  endfunction

  // driver: apply one operation on the falling edge and record what should appear next cycle
  task automatic drive(input logic rst_v, input logic [1:0] op, input logic [5:0] fn,
                       input logic [W-1:0] av, input logic [W-1:0] bv, input logic br);
    @(negedge clk);
    rst    = rst_v;
    alu_op = op;
    funct  = fn;
    a      = av;
    b      = bv;
    branch = br;
    exp_q.push_back(model(rst_v, op, fn, av, bv, br));
  endtask

  // scoreboard monitor: every cycle with an outstanding expectation, compare just after the edge
  initial begin
    logic [EXP_W-1:0] exp_v;
    logic [EXP_W-1:0] got_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {alu_ctrl, result, zero, overflow, pc_src};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL out_check #%0d: got ctrl=%b res=%h z=%b ov=%b pc=%b, expected ctrl=%b res=%h z=%b ov=%b pc=%b",
                   checks, got_v[EXP_W-1 -: 4], got_v[W+2:3], got_v[2], got_v[1], got_v[0],
                   exp_v[EXP_W-1 -: 4], exp_v[W+2:3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  function automatic logic [5:0] pick_funct();
    logic [5:0] valid_fn[6];
    valid_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    if ($urandom_range(0, 4) == 0) return 6'($urandom);
    return valid_fn[$urandom_range(0, 5)];
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] edge_v[6];
    edge_v = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h1, 32'h1234};
    if ($urandom_range(0, 3) == 0) return edge_v[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    int wait_cycles;
    checks = 0;
    errors = 0;
    done   = 1'b0;
    rst = 1'b0; alu_op = 2'd0; funct = 6'd0; a = '0; b = '0; branch = 1'b0;

    // reset held for two cycles with random inputs
    repeat (2) drive(1'b0, 2'($urandom), 6'($urandom), $urandom, $urandom, 1'b1);

    drive(1'b1, 2'b00, 6'h00, 32'd5, 32'd7, 1'b0);
    drive(1'b1, 2'b00, 6'h00, 32'h7FFFFFFF, 32'd1, 1'b0);
    drive(1'b1, 2'b01, 6'h00, 32'h1234, 32'h1234, 1'b1);
    drive(1'b1, 2'b01, 6'h00, 32'd9, 32'd4, 1'b1);
    drive(1'b1, 2'b10, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    drive(1'b1, 2'b10, 6'h25, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    drive(1'b1, 2'b10, 6'h27, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    drive(1'b1, 2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1, 1'b0);
    drive(1'b1, 2'b10, 6'h2A, 32'd1, 32'hFFFFFFFF, 1'b1);
    drive(1'b1, 2'b10, 6'h07, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    drive(1'b1, 2'b01, 6'h00, 32'h80000000, 32'd1, 1'b0);
    drive(1'b1, 2'b11, 6'h00, 32'h0, 32'h0, 1'b1);
    drive(1'b1, 2'b00, 6'h00, 32'h80000000, 32'h80000000, 1'b1);
    // reset mid-stream must discard the in-flight operation
    drive(1'b0, 2'b00, 6'h00, 32'd3, 32'd4, 1'b1);
    drive(1'b1, 2'b10, 6'h22, 32'd4, 32'd4, 1'b1);

    // random back-to-back traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 19) != 0), 2'($urandom), pick_funct(),
            pick_operand(), pick_operand(), 1'($urandom));
    end

    // drain with a bounded wait
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
